ppu_pal_mux: RTL and testbench

- Parametrised palette-RAM and pixel-priority compositor for the PPU.
- Takes per-pixel background and sprite palette indices from the bg/spr generators, resolves priority, looks up the system colour through an internal palette RAM, and delivers a registered colour index to ppu_vga.
- Adds what the current inline logic lacks: parametrised depth/width, pipelined registered lookup, greyscale and colour-emphasis modes, a registered CPU read port, and a latched primary-object collision flag with explicit frame clear.

---
 rtl/ppu_pkg.sv | 33 +++
 rtl/ppu_pal_ram.sv | 42 ++++
 rtl/ppu_pal_mux.sv | 129 ++++++++++++
 tb/tb_ppu_pal_mux.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU palette helpers: default widths, transparency test,
// palette address mirroring and the greyscale mask.
package ppu_pkg;

   localparam int unsigned PAL_A_W_DEF = 5;
   localparam int unsigned COLOR_W_DEF = 6;
   localparam int unsigned A_MAX_W     = 16;
   localparam int unsigned C_MAX_W     = 16;

   // Palette index is transparent when its low two bits are zero.
   function automatic logic is_transp(input logic [1:0] idx_lo);
      return ~|idx_lo;
   endfunction

   // Entries with addr[1:0]==0 in the sprite half alias onto the background half.
   function automatic logic [A_MAX_W-1:0] pal_mirror(input logic [A_MAX_W-1:0] x,
                                                     input int unsigned        a_w,
                                                     input logic               en);
      logic [A_MAX_W-1:0] r;
      r = x;
      if (en && is_transp(x[1:0]))
         r = x & ~(A_MAX_W'(1) << (a_w - 1));
      return r;
   endfunction

   // Greyscale keeps only the two luminance MSBs of the colour index.
   function automatic logic [C_MAX_W-1:0] grey_mask(input int unsigned c_w);
      return C_MAX_W'(3) << (c_w - 2);
   endfunction

   localparam logic [COLOR_W_DEF-1:0] GREY_MASK = COLOR_W_DEF'(grey_mask(COLOR_W_DEF));

endpackage

// File: rtl/ppu_pal_ram.sv
// Palette storage: register array with synchronous reset load, one write
// port and two combinational read ports. Readers register the data on the
// same edge as a write, so they observe the old contents (read-first).
//   i_wr/i_wa/i_wd       : write port
//   i_pix_a/o_pix_d_c    : pixel pipeline read port
//   i_cpu_a/o_cpu_d_c    : CPU read port
module ppu_pal_ram
   import ppu_pkg::*;
#(
   parameter int unsigned    A_W     = PAL_A_W_DEF,
   parameter int unsigned    D_W     = COLOR_W_DEF,
   parameter logic [D_W-1:0] RST_VAL = '0
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           i_wr,
   input  logic [A_W-1:0] i_wa,
   input  logic [D_W-1:0] i_wd,
   input  logic [A_W-1:0] i_pix_a,
   output logic [D_W-1:0] o_pix_d_c,
   input  logic [A_W-1:0] i_cpu_a,
   output logic [D_W-1:0] o_cpu_d_c
);

   localparam int unsigned DEPTH = 2 ** A_W;

   logic [D_W-1:0] r_mem [DEPTH];

   // Reset loads every entry; otherwise single write port.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= RST_VAL;
      end else if (i_wr) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_pix_d_c = r_mem[i_pix_a];
   assign o_cpu_d_c = r_mem[i_cpu_a];

endmodule

// File: rtl/ppu_pal_mux.sv
// PPU pixel compositor: resolves bg/sprite priority, looks the winner up in
// the palette RAM through a two-stage registered pipeline, applies
// greyscale, aligns emphasis bits and keeps a sticky primary-object
// collision flag. Also provides a registered CPU palette read port.
//   pram_*           : CPU palette access (write strobe, registered read)
//   bg/spr_*_in      : per-pixel layer indices and sprite attributes
//   pix_pulse_in     : new pixel present; result appears 2 clocks later
//   sys_idx_out etc. : registered colour, emphasis, valid pulse, collision
module ppu_pal_mux
   import ppu_pkg::*;
#(
   parameter int unsigned        PAL_A_W   = PAL_A_W_DEF,
   parameter int unsigned        COLOR_W   = COLOR_W_DEF,
   parameter bit                 MIRROR_EN = 1'b1,
   parameter logic [COLOR_W-1:0] RST_COLOR = COLOR_W'(6'h0f)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [PAL_A_W-1:0] pram_a_in,
   input  logic [COLOR_W-1:0] pram_d_in,
   input  logic               pram_wr_in,
   output logic [COLOR_W-1:0] pram_d_out,
   input  logic [PAL_A_W-2:0] bg_idx_in,
   input  logic [PAL_A_W-2:0] spr_idx_in,
   input  logic               spr_primary_in,
   input  logic               spr_priority_in,
   input  logic               pix_pulse_in,
   input  logic               frame_start_in,
   input  logic               greyscale_in,
   input  logic [2:0]         emph_in,
   output logic [COLOR_W-1:0] sys_idx_out,
   output logic [2:0]         emph_out,
   output logic               pix_valid_out,
   output logic               pri_col_out
);

   localparam logic [COLOR_W-1:0] GREY_M = COLOR_W'(grey_mask(COLOR_W));

   logic               w_spr_t;
   logic               w_bg_t;
   logic [PAL_A_W-1:0] w_sel_addr;
   logic [PAL_A_W-1:0] w_wr_a;
   logic [PAL_A_W-1:0] w_pix_a;
   logic [PAL_A_W-1:0] w_cpu_a;
   logic [COLOR_W-1:0] w_pix_d;
   logic [COLOR_W-1:0] w_cpu_d;

   logic [PAL_A_W-1:0] r_addr1;
   logic               r_grey1;
   logic [2:0]         r_emph1;
   logic               r_v1;
   logic [COLOR_W-1:0] r_sys;
   logic [2:0]         r_emph;
   logic               r_valid;
   logic               r_col;
   logic [COLOR_W-1:0] r_cpu_d;

   assign w_spr_t = is_transp(spr_idx_in[1:0]);
   assign w_bg_t  = is_transp(bg_idx_in[1:0]);

   // Opaque sprite wins unless it is behind an opaque background.
   always_comb begin
      w_sel_addr = '0;
      if (!w_spr_t && (!spr_priority_in || w_bg_t))
         w_sel_addr = {1'b1, spr_idx_in};
      else if (!w_bg_t)
         w_sel_addr = {1'b0, bg_idx_in};
   end

   assign w_wr_a  = PAL_A_W'(pal_mirror(A_MAX_W'(pram_a_in), PAL_A_W, MIRROR_EN));
   assign w_pix_a = PAL_A_W'(pal_mirror(A_MAX_W'(r_addr1),   PAL_A_W, MIRROR_EN));
   assign w_cpu_a = w_wr_a;

   ppu_pal_ram #(
      .A_W     (PAL_A_W),
      .D_W     (COLOR_W),
      .RST_VAL (RST_COLOR)
   ) u_ram (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .i_wr      (pram_wr_in),
      .i_wa      (w_wr_a),
      .i_wd      (pram_d_in),
      .i_pix_a   (w_pix_a),
      .o_pix_d_c (w_pix_d),
      .i_cpu_a   (w_cpu_a),
      .o_cpu_d_c (w_cpu_d)
   );

   // Stage 1 capture, stage 2 lookup/register, CPU read and collision flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_addr1 <= '0;
         r_grey1 <= 1'b0;
         r_emph1 <= '0;
         r_v1    <= 1'b0;
         r_sys   <= '0;
         r_emph  <= '0;
         r_valid <= 1'b0;
         r_col   <= 1'b0;
         r_cpu_d <= '0;
      end else begin
         r_v1 <= pix_pulse_in;
         if (pix_pulse_in) begin
            r_addr1 <= w_sel_addr;
            r_grey1 <= greyscale_in;
            r_emph1 <= emph_in;
         end
         r_valid <= r_v1;
         if (r_v1) begin
            r_sys  <= w_pix_d & (r_grey1 ? GREY_M : '1);
            r_emph <= r_emph1;
         end
         r_cpu_d <= w_cpu_d;
         // Clear has priority over a coincident set.
         if (frame_start_in)
            r_col <= 1'b0;
         else if (pix_pulse_in && spr_primary_in && !w_spr_t && !w_bg_t)
            r_col <= 1'b1;
      end
   end

   assign sys_idx_out   = r_sys;
   assign emph_out      = r_emph;
   assign pix_valid_out = r_valid;
   assign pri_col_out   = r_col;
   assign pram_d_out    = r_cpu_d;

endmodule

// File: tb/tb_ppu_pal_mux.sv
// Self-checking bench for ppu_pal_mux: directed table vectors, hand-written
// corner sequences and randomized traffic against a cycle reference model.
module tb_ppu_pal_mux;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] pa;
   logic [5:0] pd;
   logic       pwr;
   logic [3:0] bg, spr;
   logic       prim, pri, pulse, fs, grey;
   logic [2:0] emph;

   logic [5:0] pd_o, sys;
   logic [2:0] emo;
   logic       pv, col;
   logic [5:0] nm_pd_o, nm_sys;
   logic [2:0] nm_emo;
   logic       nm_pv, nm_col;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ppu_pal_mux dut (
      .clk_in(clk), .rst_in(rst), .pram_a_in(pa), .pram_d_in(pd), .pram_wr_in(pwr),
      .pram_d_out(pd_o), .bg_idx_in(bg), .spr_idx_in(spr), .spr_primary_in(prim),
      .spr_priority_in(pri), .pix_pulse_in(pulse), .frame_start_in(fs),
      .greyscale_in(grey), .emph_in(emph), .sys_idx_out(sys), .emph_out(emo),
      .pix_valid_out(pv), .pri_col_out(col)
   );

   ppu_pal_mux #(.MIRROR_EN(1'b0)) dut_nm (
      .clk_in(clk), .rst_in(rst), .pram_a_in(pa), .pram_d_in(pd), .pram_wr_in(pwr),
      .pram_d_out(nm_pd_o), .bg_idx_in(bg), .spr_idx_in(spr), .spr_primary_in(prim),
      .spr_priority_in(pri), .pix_pulse_in(pulse), .frame_start_in(fs),
      .greyscale_in(grey), .emph_in(emph), .sys_idx_out(nm_sys), .emph_out(nm_emo),
      .pix_valid_out(nm_pv), .pri_col_out(nm_col)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   int m_pal [32];
   bit s1_v, s1_g;
   int s1_a, s1_e;
   int e_sys, e_emph, e_rd;
   bit e_v, e_col;

   function automatic int mapa(input int a);
      return (a % 4 == 0) ? a % 16 : a;
   endfunction

   function automatic int winner(input int b, input int s, input bit behind);
      bit s_op = (s % 4) != 0;
      bit b_op = (b % 4) != 0;
      if (s_op && (!behind || !b_op)) return 16 + s;
      if (b_op) return b;
      return 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_pal[i] = 'h0f;
         s1_v = 0; e_v = 0; e_sys = 0; e_emph = 0; e_col = 0; e_rd = 0;
      end else begin
         e_v = s1_v;
         if (s1_v) begin
            e_sys  = m_pal[mapa(s1_a)] & (s1_g ? 'h30 : 'h3f);
            e_emph = s1_e;
         end
         e_rd = m_pal[mapa(int'(pa))];
         if (fs) e_col = 0;
         else if (pulse && prim && (spr % 4 != 0) && (bg % 4 != 0)) e_col = 1;
         s1_v = pulse;
         s1_a = winner(int'(bg), int'(spr), pri);
         s1_g = grey;
         s1_e = int'(emph);
         if (pwr) m_pal[mapa(int'(pa))] = int'(pd);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_sys",   sys,  e_sys);
         chk("mdl_emph",  emo,  e_emph);
         chk("mdl_valid", pv,   e_v);
         chk("mdl_col",   col,  e_col);
         chk("mdl_rd",    pd_o, e_rd);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wr(input logic [4:0] a, input logic [5:0] d);
      pa = a; pd = d; pwr = 1'b1;
      nxt();
      pwr = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [4:0] a, input logic [5:0] exp);
      pa = a;
      nxt();
      chk(nm, pd_o, exp);
   endtask

   typedef struct {
      logic [3:0] bg;
      logic [3:0] spr;
      logic       pri;
      logic       grey;
      logic [2:0] emph;
      logic [5:0] exp_sys;
      logic [2:0] exp_emph;
   } vec_t;

   vec_t vt [7];

   int cnt, first, last;

   initial begin
      rst = 1'b1; pa = '0; pd = '0; pwr = 1'b0; bg = '0; spr = '0;
      prim = 1'b0; pri = 1'b0; pulse = 1'b0; fs = 1'b0; grey = 1'b0; emph = '0;

      vt[0] = '{4'h6, 4'h5, 1'b0, 1'b0, 3'd0, 6'h2a, 3'd0};
      vt[1] = '{4'h6, 4'h5, 1'b1, 1'b0, 3'd0, 6'h16, 3'd0};
      vt[2] = '{4'h6, 4'h4, 1'b0, 1'b0, 3'd0, 6'h16, 3'd0};
      vt[3] = '{4'h4, 4'h8, 1'b0, 1'b0, 3'd2, 6'h21, 3'd2};
      vt[4] = '{4'h6, 4'h5, 1'b1, 1'b1, 3'd5, 6'h10, 3'd5};
      vt[5] = '{4'h0, 4'h5, 1'b1, 1'b0, 3'd7, 6'h2a, 3'd7};
      vt[6] = '{4'h6, 4'h5, 1'b0, 1'b1, 3'd3, 6'h20, 3'd3};

      // Reset state
      nxt(); nxt();
      rst = 1'b0;
      chk_en = 1'b1;
      nxt();
      chk("rst_rd00", pd_o, 6'h0f);
      chk("rst_sys",  sys,  6'h00);
      chk("rst_emph", emo,  3'd0);
      chk("rst_pv",   pv,   1'b0);
      chk("rst_col",  col,  1'b0);
      chk("rst_nm_out", {nm_sys, nm_emo, nm_pv, nm_col}, 32'h0);
      rd("rst_rd1f", 5'h1f, 6'h0f);

      // Mirroring
      wr(5'h10, 6'h21);
      rd("mir_rd00", 5'h00, 6'h21);
      chk("nomir_rd00", nm_pd_o, 6'h0f);
      wr(5'h11, 6'h15);
      rd("mir_rd01", 5'h01, 6'h0f);

      // Priority / greyscale table
      wr(5'h06, 6'h16);
      wr(5'h15, 6'h2a);
      for (int i = 0; i < 7; i++) begin
         bg = vt[i].bg; spr = vt[i].spr; pri = vt[i].pri;
         grey = vt[i].grey; emph = vt[i].emph; pulse = 1'b1;
         nxt();
         pulse = 1'b0;
         chk($sformatf("vec%0d_lat1", i), pv, 1'b0);
         nxt();
         chk($sformatf("vec%0d_pv", i),   pv,  1'b1);
         chk($sformatf("vec%0d_sys", i),  sys, vt[i].exp_sys);
         chk($sformatf("vec%0d_emph", i), emo, vt[i].exp_emph);
         nxt();
         chk($sformatf("vec%0d_hold", i), {pv, sys}, {1'b0, vt[i].exp_sys});
      end

      // Back-to-back pixels
      bg = 4'h6; spr = 4'h0; pri = 1'b0; grey = 1'b1; emph = 3'b101; pulse = 1'b1;
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 12; i++) begin
         nxt();
         if (i == 7) pulse = 1'b0;
         if (pv) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      chk("b2b_count", cnt, 8);
      chk("b2b_first", first, 1);
      chk("b2b_last",  last, 8);
      chk("b2b_sys",   sys, 6'h10);
      grey = 1'b0; emph = '0;

      // Collision flag
      prim = 1'b1; pri = 1'b1; bg = 4'h1; spr = 4'h1; pulse = 1'b1;
      nxt();
      pulse = 1'b0; prim = 1'b0;
      chk("col_set", col, 1'b1);
      nxt(); nxt();
      chk("col_sticky", col, 1'b1);
      prim = 1'b1; pulse = 1'b1; fs = 1'b1;
      nxt();
      prim = 1'b0; pulse = 1'b0; fs = 1'b0;
      chk("col_clr_wins", col, 1'b0);
      nxt();
      chk("col_stay_clr", col, 1'b0);

      // Write/read collision on the entry stage 2 is reading
      bg = 4'h6; spr = 4'h0; pa = 5'h06; pulse = 1'b1;
      nxt();
      pulse = 1'b0; pd = 6'h33; pwr = 1'b1;
      nxt();
      pwr = 1'b0;
      chk("wrc_pv",  pv,   1'b1);
      chk("wrc_old", sys,  6'h16);
      chk("wrc_rd_old", pd_o, 6'h16);
      pulse = 1'b1;
      nxt();
      pulse = 1'b0;
      chk("wrc_rd_new", pd_o, 6'h33);
      nxt();
      chk("wrc_new", sys, 6'h33);

      // Reset with a pixel in flight
      pulse = 1'b1;
      nxt();
      pulse = 1'b0; rst = 1'b1;
      nxt();
      rst = 1'b0;
      chk("rstf_pv",  pv,  1'b0);
      chk("rstf_sys", sys, 6'h00);
      chk("rstf_rd",  pd_o, 6'h00);
      nxt();
      chk("rstf_pv2", pv,  1'b0);
      chk("rstf_pal", pd_o, 6'h0f);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         pa    = 5'($urandom_range(0, 31));
         pd    = 6'($urandom_range(0, 63));
         pwr   = ($urandom_range(0, 3) == 0);
         bg    = 4'($urandom_range(0, 15));
         spr   = 4'($urandom_range(0, 15));
         prim  = ($urandom_range(0, 3) == 0);
         pri   = 1'($urandom_range(0, 1));
         pulse = 1'($urandom_range(0, 1));
         fs    = ($urandom_range(0, 15) == 0);
         grey  = ($urandom_range(0, 3) == 0);
         emph  = 3'($urandom_range(0, 7));
         nxt();
      end
      rst = 1'b0; pwr = 1'b0; pulse = 1'b0; fs = 1'b0;
      nxt(); nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
